// File: rtl/kpu_pkg.sv
// Shared KPU definitions: memory op-codes driven by the core and the
// memory-controller state encoding.
package kpu_pkg;

    localparam logic [31:0] MEMOP_IDLE  = 32'd0;
    localparam logic [31:0] MEMOP_READ  = 32'd1;
    localparam logic [31:0] MEMOP_WRITE = 32'd2;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone,
        StRelease
    } mem_state_e;

endpackage

// File: rtl/kpu_mem_ctrl_if.sv
// Core-side memory port of the KPU: request from the core, completion and
// read data back from the memory controller.
interface kpu_mem_ctrl_if;

    logic [31:0] memop;
    logic [31:0] memaddress;
    logic [31:0] memwdata;
    logic [31:0] memrdata;
    logic        memready;
    logic        memerr;

    modport master (
        output memop,
        output memaddress,
        output memwdata,
        input  memrdata,
        input  memready,
        input  memerr
    );

    modport slave (
        input  memop,
        input  memaddress,
        input  memwdata,
        output memrdata,
        output memready,
        output memerr
    );

endinterface

// File: rtl/kpu_mem_ctrl.sv
// Word memory controller between the KPU core and a synchronous single-port
// SRAM: wait-stated accesses, error rejection, and a release handshake.
module kpu_mem_ctrl
    import kpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    kpu_mem_ctrl_if.slave         bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_re,
    output logic                  sram_we,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    mem_state_e            state_q;
    logic [3:0]            cnt_q;
    logic [31:0]           memrdata_q;
    logic                  memready_q;
    logic                  memerr_q;
    logic [ADDR_WIDTH-1:0] sram_addr_q;
    logic                  sram_re_q;
    logic                  sram_we_q;
    logic [31:0]           sram_wdata_q;

    logic op_valid;
    logic misaligned;
    logic out_of_range;
    logic req_err;

    always_comb begin
        op_valid     = (bus.memop == MEMOP_READ) || (bus.memop == MEMOP_WRITE);
        misaligned   = bus.memaddress[1:0] != 2'b00;
        out_of_range = (bus.memaddress >> (ADDR_WIDTH + 2)) != 32'd0;
        req_err      = !op_valid || misaligned || out_of_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            memrdata_q   <= 32'd0;
            memready_q   <= 1'b0;
            memerr_q     <= 1'b0;
            sram_addr_q  <= '0;
            sram_re_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.memop != MEMOP_IDLE) begin
                        if (req_err) begin
                            // Rejected without touching the SRAM; only writes keep read data.
                            state_q    <= StDone;
                            memready_q <= 1'b1;
                            memerr_q   <= 1'b1;
                            if (bus.memop != MEMOP_WRITE) memrdata_q <= 32'd0;
                        end else begin
                            state_q      <= StAccess;
                            cnt_q        <= 4'(WAIT_STATES);
                            sram_addr_q  <= bus.memaddress[ADDR_WIDTH+1:2];
                            sram_wdata_q <= bus.memwdata;
                            sram_re_q    <= bus.memop == MEMOP_READ;
                            sram_we_q    <= bus.memop == MEMOP_WRITE;
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        if (sram_re_q) memrdata_q <= sram_rdata;
                        sram_re_q  <= 1'b0;
                        sram_we_q  <= 1'b0;
                        memready_q <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    memready_q <= 1'b0;
                    memerr_q   <= 1'b0;
                    state_q    <= StRelease;
                end
                StRelease: begin
                    // A core still holding its request must not be served twice.
                    if (bus.memop == MEMOP_IDLE) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.memrdata = memrdata_q;
    assign bus.memready = memready_q;
    assign bus.memerr   = memerr_q;
    assign sram_addr    = sram_addr_q;
    assign sram_re      = sram_re_q;
    assign sram_we      = sram_we_q;
    assign sram_wdata   = sram_wdata_q;

endmodule

// File: tb/tb_kpu_mem_ctrl.sv
// Bench for kpu_mem_ctrl: directed scenarios plus randomized requests checked
// against a word-array reference model of the memory.
module tb_kpu_mem_ctrl;
    import kpu_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned WS = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kpu_mem_ctrl_if bus ();
    logic [AW-1:0] sram_addr;
    logic          sram_re;
    logic          sram_we;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    kpu_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .WAIT_STATES(WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_re   (sram_re),
        .sram_we   (sram_we),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    // Small SRAM: all addresses used by the bench fall in the first 128 words.
    logic [31:0] sram_mem [0:127];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) sram_mem[i] <= 32'd0;
        end else if (sram_we) begin
            sram_mem[sram_addr[6:0]] <= sram_wdata;
        end
    end
    assign sram_rdata = ((sram_addr >> 7) == '0) ? sram_mem[sram_addr[6:0]] : 32'hBAD0_0000;

    logic [31:0] ref_mem [0:127];
    logic [31:0] exp_rdata;
    int n_cmp = 0;
    int n_bad = 0;

    // Issues one request in an IDLE cycle and observes it until completion and release.
    task automatic do_req(input logic [31:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rdata, output logic err,
                          output int re_n, output int we_n, output int bad);
        lat = 0; re_n = 0; we_n = 0; bad = 0; rdata = 32'd0; err = 1'b0;
        @(negedge clk);
        bus.memop = op; bus.memaddress = addr; bus.memwdata = wdata;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.memaddress = $urandom;
            bus.memwdata   = $urandom;
            if (sram_re) begin
                re_n++;
                if (sram_addr !== addr[AW+1:2]) bad++;
            end
            if (sram_we) begin
                we_n++;
                if (sram_addr !== addr[AW+1:2] || sram_wdata !== wdata) bad++;
            end
            if (sram_re && sram_we) bad++;
            if (bus.memerr && !bus.memready) bad++;
            if (bus.memready) begin
                lat = c; rdata = bus.memrdata; err = bus.memerr;
                break;
            end
        end
        bus.memop = MEMOP_IDLE;
        @(negedge clk);
        if (bus.memready !== 1'b0 || bus.memerr !== 1'b0 || sram_re || sram_we) bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        bus.memop = MEMOP_IDLE; bus.memaddress = 32'd0; bus.memwdata = 32'd0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'd0;
        exp_rdata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.memready, bus.memerr, sram_re, sram_we} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_ctrl cyc%0d: got %b expected 0000", c,
                         {bus.memready, bus.memerr, sram_re, sram_we});
            end
            n_cmp++;
            if (bus.memrdata !== 32'd0 || sram_addr !== '0 || sram_wdata !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_data cyc%0d: got rdata=%h addr=%h wdata=%h expected 0",
                         c, bus.memrdata, sram_addr, sram_wdata);
            end
        end
    endtask

    task automatic test_write_read();
        int lat, re_n, we_n, bad;
        logic [31:0] rd;
        logic er;
        do_req(MEMOP_WRITE, 32'h10, 32'hDEAD_BEEF, lat, rd, er, re_n, we_n, bad);
        ref_mem[4] = 32'hDEAD_BEEF;
        n_cmp++;
        if (we_n !== 2 || re_n !== 0) begin
            n_bad++; $display("FAIL wr_strobes: got we=%0d re=%0d expected we=2 re=0", we_n, re_n);
        end
        n_cmp++;
        if (lat !== 3 || er !== 1'b0 || bad !== 0) begin
            n_bad++; $display("FAIL wr_done: got lat=%0d err=%b viol=%0d expected 3 0 0",
                              lat, er, bad);
        end
        do_req(MEMOP_READ, 32'h10, 32'h0, lat, rd, er, re_n, we_n, bad);
        exp_rdata = 32'hDEAD_BEEF;
        n_cmp++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rd_done: got lat=%0d err=%b data=%h expected 3 0 deadbeef",
                              lat, er, rd);
        end
        n_cmp++;
        if (re_n !== 2 || we_n !== 0 || bad !== 0) begin
            n_bad++; $display("FAIL rd_strobes: got re=%0d we=%0d viol=%0d expected 2 0 0",
                              re_n, we_n, bad);
        end
    endtask

    task automatic test_errors();
        int lat, re_n, we_n, bad;
        logic [31:0] rd;
        logic er;
        logic [31:0] ops   [5] = '{32'd1, 32'd1, 32'd7, 32'd2, 32'd1};
        logic [31:0] addrs [5] = '{32'h12, 32'h10, 32'h10, 32'h13, 32'h0004_0000};
        logic [31:0] exps  [5] = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
        logic        errs  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            do_req(ops[k], addrs[k], 32'h1234_5678, lat, rd, er, re_n, we_n, bad);
            n_cmp++;
            if (er !== errs[k] || lat !== (errs[k] ? 1 : 3)) begin
                n_bad++; $display("FAIL err%0d_resp: got err=%b lat=%0d expected err=%b", k, er,
                                  lat, errs[k]);
            end
            n_cmp++;
            if (rd !== exps[k]) begin
                n_bad++; $display("FAIL err%0d_data: got %h expected %h", k, rd, exps[k]);
            end
            n_cmp++;
            if ((errs[k] && (re_n + we_n) !== 0) || bad !== 0) begin
                n_bad++; $display("FAIL err%0d_sram: got strobes=%0d viol=%0d expected 0 0", k,
                                  re_n + we_n, bad);
            end
        end
        exp_rdata = 32'd0;
    endtask

    task automatic test_hold();
        int re_n = 0;
        int rdy_n = 0;
        int lat, we_n, bad;
        logic [31:0] rd;
        logic er;
        logic [31:0] got = 32'd0;
        @(negedge clk);
        bus.memop = MEMOP_READ; bus.memaddress = 32'h10;
        for (int c = 1; c <= int'(WS) + 12; c++) begin
            @(negedge clk);
            if (sram_re) re_n++;
            if (bus.memready) begin rdy_n++; got = bus.memrdata; end
        end
        n_cmp++;
        if (re_n !== int'(WS) + 1 || rdy_n !== 1 || got !== ref_mem[4]) begin
            n_bad++; $display("FAIL hold: got re=%0d ready=%0d data=%h expected %0d 1 %h", re_n,
                              rdy_n, got, WS + 1, ref_mem[4]);
        end
        bus.memop = MEMOP_IDLE;
        @(negedge clk);
        do_req(MEMOP_READ, 32'h10, 32'h0, lat, rd, er, re_n, we_n, bad);
        n_cmp++;
        if (lat !== 3 || rd !== ref_mem[4] || er !== 1'b0 || bad !== 0) begin
            n_bad++; $display("FAIL hold_next: got lat=%0d data=%h err=%b viol=%0d", lat, rd, er,
                              bad);
        end
        exp_rdata = ref_mem[4];
    endtask

    task automatic test_reset_mid();
        int lat, re_n, we_n, bad;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        bus.memop = MEMOP_WRITE; bus.memaddress = 32'h190; bus.memwdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++;
        if (sram_we !== 1'b1) begin
            n_bad++; $display("FAIL mid_access: got we=%b expected 1", sram_we);
        end
        rst = 1'b1; bus.memop = MEMOP_IDLE;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'd0;
        n_cmp++;
        if ({sram_we, sram_re, bus.memready, bus.memerr} !== 4'b0000 ||
            bus.memrdata !== 32'd0 || sram_addr !== '0 || sram_wdata !== 32'd0) begin
            n_bad++; $display("FAIL mid_reset: got we=%b re=%b rdy=%b err=%b rdata=%h expected 0",
                              sram_we, sram_re, bus.memready, bus.memerr, bus.memrdata);
        end
        do_req(MEMOP_READ, 32'h10, 32'h0, lat, rd, er, re_n, we_n, bad);
        exp_rdata = ref_mem[4];
        n_cmp++;
        if (lat !== 3 || rd !== ref_mem[4] || er !== 1'b0 || re_n !== 2 || bad !== 0) begin
            n_bad++; $display("FAIL mid_after: got lat=%0d data=%h err=%b re=%0d viol=%0d",
                              lat, rd, er, re_n, bad);
        end
    endtask

    task automatic test_random();
        int lat, re_n, we_n, bad, e_lat, e_re, e_we;
        logic [31:0] rd, op, addr, wd;
        logic er, e_err;
        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 9);
            int r = $urandom_range(0, 9);
            op   = (k == 0) ? 32'd3 + $urandom_range(0, 100) : (k < 5) ? MEMOP_READ : MEMOP_WRITE;
            addr = 32'($urandom_range(0, 31)) * 4;
            if (r == 0) addr = addr + 32'($urandom_range(1, 3));
            if (r == 1) addr = ($urandom | 32'h0004_0000) & ~32'h3;
            wd = $urandom;
            e_err = !(op == MEMOP_READ || op == MEMOP_WRITE) || (addr % 4) != 0 ||
                    64'(addr) >= (64'd4 << AW);
            e_lat = e_err ? 1 : int'(WS) + 2;
            e_re  = (!e_err && op == MEMOP_READ)  ? int'(WS) + 1 : 0;
            e_we  = (!e_err && op == MEMOP_WRITE) ? int'(WS) + 1 : 0;
            if (!e_err && op == MEMOP_READ) exp_rdata = ref_mem[addr / 4];
            if (e_err && op != MEMOP_WRITE) exp_rdata = 32'd0;
            if (!e_err && op == MEMOP_WRITE) ref_mem[addr / 4] = wd;
            do_req(op, addr, wd, lat, rd, er, re_n, we_n, bad);
            n_cmp++;
            if (lat !== e_lat) begin
                n_bad++; $display("FAIL rnd%0d_lat: got %0d expected %0d", n, lat, e_lat);
            end
            n_cmp++;
            if (er !== e_err) begin
                n_bad++; $display("FAIL rnd%0d_err: got %b expected %b", n, er, e_err);
            end
            n_cmp++;
            if (rd !== exp_rdata) begin
                n_bad++; $display("FAIL rnd%0d_data: got %h expected %h", n, rd, exp_rdata);
            end
            n_cmp++;
            if (re_n !== e_re) begin
                n_bad++; $display("FAIL rnd%0d_re: got %0d expected %0d", n, re_n, e_re);
            end
            n_cmp++;
            if (we_n !== e_we) begin
                n_bad++; $display("FAIL rnd%0d_we: got %0d expected %0d", n, we_n, e_we);
            end
            n_cmp++;
            if (bad !== 0) begin
                n_bad++; $display("FAIL rnd%0d_bus: got %0d violations expected 0", n, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
